fetch_unit: RTL and testbench



---
 rtl/fetch_pkg.sv | 22 ++
 rtl/fetch_fifo.sv | 89 ++++++++
 rtl/fetch_unit.sv | 135 +++++++++++++
 tb/tb_fetch_unit.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

    localparam int FETCH_DATA_WIDTH = 32;
    localparam int FETCH_ADDR_WIDTH = 32;

    // Canonical RISC-V NOP (addi x0, x0, 0), available for bubble insertion.
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // One prefetch buffer entry: the fetched word tagged with its address.
    typedef struct packed {
        logic [FETCH_ADDR_WIDTH-1:0] pc;
        logic [FETCH_DATA_WIDTH-1:0] instr;
    } fetch_entry_t;

    // Width of a counter that has to hold every value from 0 to depth inclusive.
    function automatic int count_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch buffer: synchronous FIFO with flush and a registered head output.
// The head register is loaded from storage (or straight from the write data
// when the FIFO is, or becomes, empty), so a pushed word is visible one
// cycle after the push and never combinationally.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type entry_t = fetch_entry_t,
    localparam int CW      = count_width(DEPTH)
) (
    input  logic          clk,
    input  logic          srst,
    input  logic          push,
    input  entry_t        push_data,
    input  logic          pop,
    input  logic          flush,
    output entry_t        head,
    output logic          empty,
    output logic [CW-1:0] count
);

    localparam int PW = $clog2(DEPTH);

    entry_t        mem [DEPTH];
    entry_t        head_reg;
    logic [PW-1:0] wr_ptr_reg;
    logic [PW-1:0] rd_ptr_reg;
    logic [PW-1:0] rd_ptr_next;
    logic [CW-1:0] count_reg;
    logic          full;
    logic          do_push;
    logic          do_pop;
    logic          head_from_input;

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == CW'(DEPTH));
    // A flush discards everything, including a push or pop in the same cycle.
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;

    assign rd_ptr_next     = do_pop ? rd_ptr_reg + 1'b1 : rd_ptr_reg;
    // The incoming word becomes the head when nothing older remains after the pop.
    assign head_from_input = do_push && (count_reg == CW'(do_pop));

    assign head  = head_reg;
    assign count = count_reg;

    // Storage array write port, kept free of reset so it maps onto RAM.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    // Registered read of the next head entry.
    always_ff @(posedge clk) begin
        if (srst || flush) begin
            head_reg <= '0;
        end else if (head_from_input) begin
            head_reg <= push_data;
        end else begin
            head_reg <= mem[rd_ptr_next];
        end
    end

    // Pointers and occupancy.
    always_ff @(posedge clk) begin
        if (srst || flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_reg + CW'(do_push) - CW'(do_pop);
        end
    end

    // A push into a full buffer means the upstream space reservation failed.
    always_ff @(posedge clk) begin
        if (!srst) begin
            assert (!(push && full && !flush));
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: sequential PC, pipelined request/response port to
// instruction memory, prefetch buffer toward the core, redirect with flush.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int                    DATA_WIDTH = FETCH_DATA_WIDTH,
    parameter int                    ADDR_WIDTH = FETCH_ADDR_WIDTH,
    parameter int                    FIFO_DEPTH = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(DEFAULT_RESET_PC)
) (
    input  logic                  CLK,
    input  logic                  RST,
    output logic                  imem_req,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic                  imem_ready,
    input  logic                  imem_rvalid,
    input  logic [DATA_WIDTH-1:0] imem_rdata,
    output logic                  instr_valid,
    output logic [DATA_WIDTH-1:0] instr,
    output logic [ADDR_WIDTH-1:0] instr_pc,
    input  logic                  instr_ready,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc
);

    localparam int CW = count_width(FIFO_DEPTH);

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] pc;
        logic [DATA_WIDTH-1:0] instr;
    } entry_t;

    logic [ADDR_WIDTH-1:0] fetch_pc_reg;
    logic [ADDR_WIDTH-1:0] fetch_pc_next;
    logic [ADDR_WIDTH-1:0] resp_pc_reg;
    logic [ADDR_WIDTH-1:0] resp_pc_next;
    logic [ADDR_WIDTH-1:0] redirect_target;
    logic [CW-1:0]         outstanding_reg;
    logic [CW-1:0]         outstanding_next;
    logic [CW-1:0]         discard_reg;
    logic [CW-1:0]         discard_next;
    logic [CW-1:0]         fifo_count;
    logic [CW:0]           slots_in_use;
    logic                  fifo_empty;
    logic                  req_fire;
    logic                  resp_keep;
    logic                  fifo_pop;
    entry_t                push_entry;
    entry_t                head_entry;
    logic                  unused_redirect_lsbs;

    // Targets are forced to word alignment; the low bits are deliberately ignored.
    assign redirect_target      = {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    // Every in-flight request owns a buffer slot, so responses can never overflow.
    assign slots_in_use = {1'b0, fifo_count} + {1'b0, outstanding_reg};
    assign imem_req     = !RST && !redirect_valid && (slots_in_use < (CW+1)'(FIFO_DEPTH));
    assign imem_addr    = fetch_pc_reg;
    assign req_fire     = imem_req && imem_ready;

    // A response is kept only if it belongs to the current fetch stream.
    assign resp_keep  = imem_rvalid && !redirect_valid && (discard_reg == '0);
    assign push_entry = '{pc: resp_pc_reg, instr: imem_rdata};
    assign fifo_pop   = instr_valid && instr_ready;

    fetch_fifo #(
        .DEPTH   (FIFO_DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk       (CLK),
        .srst      (RST),
        .push      (resp_keep),
        .push_data (push_entry),
        .pop       (fifo_pop),
        .flush     (redirect_valid),
        .head      (head_entry),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign instr_valid = !RST && !fifo_empty;
    assign instr       = instr_valid ? head_entry.instr : '0;
    assign instr_pc    = instr_valid ? head_entry.pc    : '0;

    // Next-state for the PCs and the in-flight / to-be-dropped counters.
    always_comb begin
        fetch_pc_next    = fetch_pc_reg;
        resp_pc_next     = resp_pc_reg;
        outstanding_next = outstanding_reg + CW'(req_fire) - CW'(imem_rvalid);
        discard_next     = discard_reg;
        if (redirect_valid) begin
            fetch_pc_next = redirect_target;
            resp_pc_next  = redirect_target;
            // Every request still in flight now belongs to a dead stream. The
            // ones already marked for discard are part of outstanding, so the
            // new total is simply what remains in flight after this cycle.
            discard_next  = outstanding_reg - CW'(imem_rvalid);
        end else begin
            if (req_fire) begin
                fetch_pc_next = fetch_pc_reg + ADDR_WIDTH'(4);
            end
            if (resp_keep) begin
                resp_pc_next = resp_pc_reg + ADDR_WIDTH'(4);
            end else if (imem_rvalid) begin
                discard_next = discard_reg - 1'b1;
            end
        end
    end

    // State registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            fetch_pc_reg    <= RESET_PC;
            resp_pc_reg     <= RESET_PC;
            outstanding_reg <= '0;
            discard_reg     <= '0;
        end else begin
            fetch_pc_reg    <= fetch_pc_next;
            resp_pc_reg     <= resp_pc_next;
            outstanding_reg <= outstanding_next;
            discard_reg     <= discard_next;
        end
    end

    // Structural invariants of the counters and the address port.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            assert (outstanding_reg <= CW'(FIFO_DEPTH));
            assert (discard_reg <= outstanding_reg);
            assert (imem_addr[1:0] == 2'b00);
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Randomised scoreboard bench for fetch_unit with an in-order variable-latency
// memory model and a stream-level reference of the expected instruction flow.
module tb_fetch_unit;

    localparam int          DEPTH  = 4;
    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        CLK = 1'b0;
    logic        RST;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    fetch_unit #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (32),
        .FIFO_DEPTH (DEPTH),
        .RESET_PC   (RST_PC)
    ) dut (
        .CLK            (CLK),
        .RST            (RST),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ready     (imem_ready),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .instr_valid    (instr_valid),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_ready    (instr_ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] addr;
        int unsigned ep;
        int unsigned due;
    } mreq_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
    } exp_t;

    mreq_t       mem_q [$];
    exp_t        exp_q [$];
    logic [31:0] redir_q [$];

    int          n_cmp   = 0;
    int          n_fail  = 0;
    int          n_cons  = 0;
    int unsigned cyc     = 0;
    int unsigned epoch   = 0;
    logic [31:0] fetch_model = RST_PC;
    logic [31:0] exp_pc      = RST_PC;

    // Stimulus knobs
    bit          rst_knob    = 1'b1;
    int          ready_pct   = 100;
    int          iready_pct  = 100;
    int          redir_pct   = 0;
    int          lat_min     = 1;
    int          lat_max     = 1;
    bit          redir_on_rv = 1'b0;
    logic [31:0] rv_target   = 32'h0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Drive inputs just after each rising edge.
    initial begin
        RST = 1'b1; imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        instr_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        forever begin
            @(posedge CLK);
            cyc++;
            #1;
            RST         = rst_knob;
            imem_ready  = ($urandom % 100) < ready_pct;
            instr_ready = ($urandom % 100) < iready_pct;
            imem_rvalid = 1'b0;
            imem_rdata  = $urandom;
            if (!rst_knob && mem_q.size() > 0) begin
                if (mem_q[0].due <= cyc) begin
                    imem_rvalid = 1'b1;
                    imem_rdata  = mem_word(mem_q[0].addr);
                end
            end
            redirect_valid = 1'b0;
            redirect_pc    = $urandom;
            if (!rst_knob) begin
                if (redir_q.size() > 0) begin
                    redirect_valid = 1'b1;
                    redirect_pc    = redir_q.pop_front();
                end else if (redir_on_rv && imem_rvalid) begin
                    redirect_valid = 1'b1;
                    redirect_pc    = rv_target;
                    instr_ready    = 1'b1;
                    redir_on_rv    = 1'b0;
                end else if (($urandom % 100) < redir_pct) begin
                    redirect_valid = 1'b1;
                    redirect_pc    = $urandom & 32'h0000_FFFF;
                end
            end
        end
    end

    // Monitor / scoreboard: compare on the falling edge, then advance the model.
    always @(negedge CLK) begin
        mreq_t m;
        exp_t  e;
        bit    exp_req;
        int    lat;
        exp_req = !RST && !redirect_valid && ((exp_q.size() + mem_q.size()) < DEPTH);
        check("imem_req", {63'd0, imem_req}, {63'd0, exp_req});
        if (imem_req) check("imem_addr", {32'd0, imem_addr}, {32'd0, fetch_model});
        check("instr_valid", {63'd0, instr_valid}, {63'd0, (!RST && exp_q.size() > 0)});
        if (!instr_valid) begin
            check("idle_instr", {32'd0, instr}, 64'd0);
            check("idle_pc", {32'd0, instr_pc}, 64'd0);
        end else if (instr_ready && !RST && !redirect_valid && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("instr_pc", {32'd0, instr_pc}, {32'd0, e.pc});
            check("instr", {32'd0, instr}, {32'd0, e.ins});
            n_cons++;
            $display("cycle %0d: consumed pc=0x%08h instr=0x%08h", cyc, instr_pc, instr);
        end

        if (RST) begin
            exp_q.delete();
            mem_q.delete();
            fetch_model = RST_PC;
            exp_pc      = RST_PC;
            epoch++;
        end else begin
            if (imem_rvalid && mem_q.size() > 0) begin
                m = mem_q.pop_front();
                if (!redirect_valid && m.ep == epoch) begin
                    exp_q.push_back('{pc: exp_pc, ins: mem_word(exp_pc)});
                    exp_pc += 32'd4;
                end
            end
            if (imem_req && imem_ready) begin
                lat = lat_min + int'($urandom % (lat_max - lat_min + 1));
                mem_q.push_back('{addr: imem_addr, ep: epoch, due: cyc + lat});
                fetch_model += 32'd4;
            end
            if (redirect_valid) begin
                exp_q.delete();
                fetch_model = {redirect_pc[31:2], 2'b00};
                exp_pc      = {redirect_pc[31:2], 2'b00};
                epoch++;
            end
        end
    end

    task automatic wait_first_pc(input string name, input logic [31:0] pc);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            @(negedge CLK);
            if (instr_valid) begin
                found = 1'b1;
                check(name, {32'd0, instr_pc}, {32'd0, pc});
            end
        end
        if (!found) check({name, "_timeout"}, {63'd0, instr_valid}, 64'd1);
    endtask

    initial begin
        int  c0;
        bit  done;
        // Reset state
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("rst_req", {63'd0, imem_req}, 64'd0);
        check("rst_valid", {63'd0, instr_valid}, 64'd0);
        @(posedge CLK);
        rst_knob = 1'b0;

        // Zero-wait memory, always-ready core: 1 instr/cycle after fill
        repeat (15) @(posedge CLK);
        c0 = n_cons;
        repeat (20) @(posedge CLK);
        check("throughput", 64'(n_cons - c0), 64'd20);

        // Core stall: issue stops once buffer plus in-flight reach depth
        iready_pct = 0;
        repeat (10) @(posedge CLK);
        @(negedge CLK);
        check("stall_req", {63'd0, imem_req}, 64'd0);
        check("stall_valid", {63'd0, instr_valid}, 64'd1);
        @(posedge CLK);
        iready_pct = 100;
        repeat (10) @(posedge CLK);

        // 3-cycle memory, redirect with requests in flight
        lat_min = 3; lat_max = 3;
        repeat (10) @(posedge CLK);
        redir_q.push_back(32'h0000_0100);
        @(posedge CLK);
        wait_first_pc("redir_100_first_pc", 32'h0000_0100);

        // Redirect coinciding with a response and a pop
        @(posedge CLK);
        rv_target   = 32'h0000_0300;
        redir_on_rv = 1'b1;
        done = 1'b0;
        for (int i = 0; i < 50 && !done; i++) begin
            @(posedge CLK);
            if (!redir_on_rv) done = 1'b1;
        end
        @(negedge CLK);
        check("rv_redir_valid", {63'd0, instr_valid}, 64'd0);
        check("rv_redir_addr", {32'd0, imem_addr}, 64'h300);
        @(posedge CLK);

        // Misaligned target is word-aligned
        redir_q.push_back(32'h0000_0203);
        @(posedge CLK);
        @(negedge CLK);
        check("align_addr", {32'd0, imem_addr}, 64'h200);
        check("align_valid", {63'd0, instr_valid}, 64'd0);
        @(posedge CLK);

        // Back-to-back redirects: last one wins
        redir_q.push_back(32'h0000_0040);
        redir_q.push_back(32'h0000_0080);
        @(posedge CLK);
        @(posedge CLK);
        wait_first_pc("b2b_first_pc", 32'h0000_0080);
        @(posedge CLK);

        // Randomised traffic
        ready_pct = 70; iready_pct = 70; redir_pct = 5; lat_min = 1; lat_max = 4;
        repeat (1500) @(posedge CLK);

        // Reset mid-stream with the buffer holding words
        ready_pct = 100; iready_pct = 0; redir_pct = 0; lat_min = 1; lat_max = 1;
        repeat (8) @(posedge CLK);
        rst_knob = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        check("mrst_valid", {63'd0, instr_valid}, 64'd0);
        check("mrst_instr", {32'd0, instr}, 64'd0);
        check("mrst_pc", {32'd0, instr_pc}, 64'd0);
        check("mrst_req", {63'd0, imem_req}, 64'd0);
        @(posedge CLK);
        rst_knob   = 1'b0;
        iready_pct = 100;
        @(negedge CLK);
        check("post_rst_req", {63'd0, imem_req}, 64'd1);
        check("post_rst_addr", {32'd0, imem_addr}, {32'd0, RST_PC});

        // Drain and confirm forward progress
        repeat (30) @(posedge CLK);
        check("progress", {63'd0, (n_cons >= 400)}, 64'd1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
